quadrilatero_mesh_deskew: RTL and testbench
===========================================

Name: quadrilatero_mesh_deskew

Overview:
Downstream stage of the systolic mesh. Consumes the bottom-edge accumulator outputs, where column j of a given row emerges j pump cycles after column 0. Delays each column so the row is realigned, then buffers complete rows in a small output FIFO with a valid/ready handshake toward the register-file writeback. Gives the controller a stall signal so in-flight rows never overflow the FIFO.

Parameters:
MESH_WIDTH, 4, number of mesh columns (= elements per row); >=1
DATA_WIDTH, 32, bits per element
FIFO_DEPTH, 4, rows held in output FIFO; >=1, power of two not required

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
flush_i  input  1  synchronous clear of delay lines, FIFO, overflow flag
pump_i  input  1  mesh advance strobe; delay lines shift only when high
acc_valid_i  input  1  column-0 element of a new row present on acc_i[0] this pump
acc_i  input  MESH_WIDTH*DATA_WIDTH  mesh acc_o; element j valid j pumps after its acc_valid_i
stall_o  output  1  controller must not assert acc_valid_i with pump_i
row_valid_o  output  1  FIFO head valid
row_ready_i  input  1  consumer accepts head
row_o  output  MESH_WIDTH*DATA_WIDTH  realigned row, element j = column j
fifo_count_o  output  $clog2(FIFO_DEPTH+1)  rows stored
overflow_o  output  1  sticky: row pushed into full FIFO without pop (dropped)

Behaviour:
- Reset/flush: all delay regs, valid chain, FIFO pointers, count, overflow_o = 0; row_valid_o=0, row_o=0, stall_o=0. Flush takes priority over push/pop in same cycle; in-flight partial rows discarded.
- Delay lines: column j has MESH_WIDTH-1-j registers, shift on pump_i only; column MESH_WIDTH-1 is a pass-through (no register).
- Valid chain: MESH_WIDTH-1 registers, head fed by acc_valid_i, shifts on pump_i; v_tail = last stage (= acc_valid_i when MESH_WIDTH=1).
- Push: cycle with pump_i && v_tail; pushed row = delayed columns 0..MESH_WIDTH-2 plus live acc_i[MESH_WIDTH-1]. Row with acc_valid_i at pump k is pushed at pump k+MESH_WIDTH-1; row_valid_o visible the following clock (FIFO storage registered).
- No pump_i: no shifting, no push, regardless of acc_valid_i/acc_i.
- Pop: row_valid_o && row_ready_i. row_o stable while row_valid_o && !row_ready_i.
- Push+pop same cycle: allowed at any occupancy incl. full; count unchanged.
- Push when full and no pop: row dropped, FIFO unchanged, overflow_o set until flush/reset.
- inflight = popcount of valid chain registers; stall_o = (fifo_count + inflight) >= FIFO_DEPTH, combinational from registers only (no path from row_ready_i).
- Pointers wrap modulo FIFO_DEPTH; empty: row_valid_o=0, row_o holds last head value (don't-care to consumer).
- acc_valid_i with pump_i while stall_o: accepted into chain (no gating); overflow handled at push as above.

Optional Feature:
QUADRILATERO_DESKEW_ROWIDX_EN: adds output row_idx_o, width $clog2(MESH_WIDTH) (1 if MESH_WIDTH=1), stored per FIFO entry; index = count of rows pushed since reset/flush modulo MESH_WIDTH, dropped rows do not increment. Without macro: port absent, no index storage.

Test Plan:
- MESH_WIDTH=4, pump every cycle, acc_valid_i at pump 0, acc_i[j]=0x11*(j+1) at pump j -> one cycle after pump 3 row_valid_o=1, row_o={0x44,0x33,0x22,0x11}, fifo_count_o=1.
- Same row, pump_i low for 2 cycles between pumps 1 and 2 -> output unchanged, row appears one cycle after pump 3 (6 clocks after start).
- FIFO_DEPTH=4, row_ready_i=0, rows entered every pump -> stall_o rises when count+inflight=4; controller respecting it yields 4 rows stored, overflow_o=0.
- Ignore stall_o, issue 5th row with ready=0 -> 5th row dropped, overflow_o=1, fifo_count_o=4, first 4 rows pop in order.
- FIFO full, push and pop same cycle -> fifo_count_o stays 4, overflow_o=0, order preserved.
- flush_i with 2 rows stored and 1 in flight -> next cycle row_valid_o=0, count=0, stall_o=0; subsequent row drains correctly (row_idx_o=0 with macro).

Source files
------------

// File: rtl/quadrilatero_mesh_deskew_if.sv
// rtl/quadrilatero_mesh_deskew_if.sv - mesh-edge input and row-writeback handshake bundle for the deskew stage.
// Optional row index lane present when QUADRILATERO_DESKEW_ROWIDX_EN is defined.
interface quadrilatero_mesh_deskew_if #(
  parameter int MESH_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = (MESH_WIDTH > 1) ? $clog2(MESH_WIDTH) : 1
) ();
  logic                           pump;
  logic                           acc_valid;
  logic [MESH_WIDTH*DATA_WIDTH-1:0] acc;
  logic                           stall;
  logic                           row_valid;
  logic                           row_ready;
  logic [MESH_WIDTH*DATA_WIDTH-1:0] row;
`ifdef QUADRILATERO_DESKEW_ROWIDX_EN
  logic [IDX_W-1:0]               row_idx;

  modport master (
    output pump, acc_valid, acc, row_ready,
    input  stall, row_valid, row, row_idx
  );
  modport slave (
    input  pump, acc_valid, acc, row_ready,
    output stall, row_valid, row, row_idx
  );
`else
  modport master (
    output pump, acc_valid, acc, row_ready,
    input  stall, row_valid, row
  );
  modport slave (
    input  pump, acc_valid, acc, row_ready,
    output stall, row_valid, row
  );
`endif
endinterface

// File: rtl/quadrilatero_mesh_deskew.sv
// rtl/quadrilatero_mesh_deskew.sv - realigns skewed mesh bottom-edge columns into rows and buffers them in an output FIFO.
// Optional per-row index output enabled by QUADRILATERO_DESKEW_ROWIDX_EN.
module quadrilatero_mesh_deskew #(
  parameter int  MESH_WIDTH = 4,
  parameter int  DATA_WIDTH = 32,
  parameter int  FIFO_DEPTH = 4,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  quadrilatero_mesh_deskew_if.slave bus,
  output logic [CNT_W-1:0]         fifo_count_o,
  output logic                     overflow_o
);

  localparam int ROW_W = MESH_WIDTH * DATA_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [ROW_W-1:0] push_row;
  logic             v_tail;
  logic [31:0]      inflight;

  // Column j is delayed by MESH_WIDTH-1-j pumps so every column lines up with the last one.
  for (genvar j = 0; j < MESH_WIDTH; j++) begin : g_col
    if (j == MESH_WIDTH - 1) begin : g_pass
      assign push_row[j*DATA_WIDTH +: DATA_WIDTH] = bus.acc[j*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_dly
      localparam int N = MESH_WIDTH - 1 - j;
      logic [DATA_WIDTH-1:0] sh_q [N];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int k = 0; k < N; k++) sh_q[k] <= '0;
        end else if (flush_i) begin
          for (int k = 0; k < N; k++) sh_q[k] <= '0;
        end else if (bus.pump) begin
          sh_q[0] <= bus.acc[j*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 1; k < N; k++) sh_q[k] <= sh_q[k-1];
        end
      end

      assign push_row[j*DATA_WIDTH +: DATA_WIDTH] = sh_q[N-1];
    end
  end

  if (MESH_WIDTH == 1) begin : g_nochain
    assign v_tail   = bus.acc_valid;
    assign inflight = '0;
  end else begin : g_chain
    logic [MESH_WIDTH-2:0] vc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vc_q <= '0;
      end else if (flush_i) begin
        vc_q <= '0;
      end else if (bus.pump) begin
        vc_q <= (vc_q << 1) | (MESH_WIDTH-1)'(bus.acc_valid);
      end
    end

    assign v_tail   = vc_q[MESH_WIDTH-2];
    assign inflight = 32'($countones(vc_q));
  end

  logic [ROW_W-1:0] mem_q [FIFO_DEPTH];
  logic [ROW_W-1:0] last_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q;
  logic             push, pop, full, do_write;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign push     = bus.pump && v_tail;
  assign pop      = bus.row_valid && bus.row_ready;
  assign do_write = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (do_write && !pop) count_d = count_q + 1'b1;
    else if (!do_write && pop) count_d = count_q - 1'b1;
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      last_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      last_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_write) begin
        mem_q[wr_ptr_q] <= push_row;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && full && !pop) overflow_q <= 1'b1;
      count_q <= count_d;
    end
  end

  // Empty FIFO keeps presenting the most recently popped head.
  assign bus.row_valid = (count_q != '0);
  assign bus.row       = bus.row_valid ? mem_q[rd_ptr_q] : last_q;
  assign bus.stall     = (32'(count_q) + inflight) >= 32'(FIFO_DEPTH);
  assign fifo_count_o  = count_q;
  assign overflow_o    = overflow_q;

`ifdef QUADRILATERO_DESKEW_ROWIDX_EN
  localparam int IDX_W = (MESH_WIDTH > 1) ? $clog2(MESH_WIDTH) : 1;

  logic [IDX_W-1:0] idx_mem_q [FIFO_DEPTH];
  logic [IDX_W-1:0] idx_last_q;
  logic [IDX_W-1:0] idx_ctr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) idx_mem_q[i] <= '0;
      idx_last_q <= '0;
      idx_ctr_q  <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) idx_mem_q[i] <= '0;
      idx_last_q <= '0;
      idx_ctr_q  <= '0;
    end else begin
      if (do_write) begin
        idx_mem_q[wr_ptr_q] <= idx_ctr_q;
        idx_ctr_q <= (32'(idx_ctr_q) == MESH_WIDTH - 1) ? '0 : idx_ctr_q + 1'b1;
      end
      if (pop) idx_last_q <= idx_mem_q[rd_ptr_q];
    end
  end

  assign bus.row_idx = bus.row_valid ? idx_mem_q[rd_ptr_q] : idx_last_q;
`endif

endmodule

// File: tb/tb_quadrilatero_mesh_deskew.sv
// tb/tb_quadrilatero_mesh_deskew.sv - directed self-checking bench for quadrilatero_mesh_deskew.
// Optional row index checks compiled in with QUADRILATERO_DESKEW_ROWIDX_EN.
module tb_quadrilatero_mesh_deskew;
  localparam int MW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic [CW-1:0] fifo_count_o;
  logic          overflow_o;

  int n_vec = 0;
  int n_err = 0;
  int pn = 0;
  bit sched_v [64];
  int sched_id [64];

  quadrilatero_mesh_deskew_if #(.MESH_WIDTH(MW), .DATA_WIDTH(DW)) bus ();

  quadrilatero_mesh_deskew #(.MESH_WIDTH(MW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .bus          (bus),
    .fifo_count_o (fifo_count_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] elem(input int id, input int j);
    return DW'(id * 256 + 17 * (j + 1));
  endfunction

  function automatic logic [MW*DW-1:0] exp_row(input int id);
    logic [MW*DW-1:0] r;
    for (int j = 0; j < MW; j++) r[j*DW +: DW] = elem(id, j);
    return r;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_sched();
    pn = 0;
    for (int i = 0; i < 64; i++) begin
      sched_v[i]  = 1'b0;
      sched_id[i] = 0;
    end
  endtask

  // Drive one pump; column j carries the element of the row that entered j pumps earlier.
  task automatic do_pump(input bit v, input int id);
    sched_v[pn]  = v;
    sched_id[pn] = id;
    for (int j = 0; j < MW; j++) begin
      if (pn - j >= 0 && sched_v[pn-j]) bus.acc[j*DW +: DW] = elem(sched_id[pn-j], j);
      else bus.acc[j*DW +: DW] = $urandom;
    end
    bus.acc_valid = v;
    bus.pump      = 1'b1;
    step();
    bus.pump      = 1'b0;
    bus.acc_valid = 1'b0;
    pn++;
  endtask

  task automatic idle_cycle();
    bus.acc       = {$urandom, $urandom, $urandom, $urandom};
    bus.acc_valid = 1'b1;
    bus.pump      = 1'b0;
    step();
    bus.acc_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    clear_sched();
  endtask

  task automatic test_reset();
    n_vec++; if (bus.row_valid !== 1'b0) begin n_err++; $display("FAIL reset_row_valid got=%b exp=0", bus.row_valid); end
    n_vec++; if (bus.row !== '0) begin n_err++; $display("FAIL reset_row got=%h exp=0", bus.row); end
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    n_vec++; if (fifo_count_o !== '0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", fifo_count_o); end
    n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
  endtask

  task automatic test_single_row();
    clear_sched();
    do_pump(1'b1, 0);
    do_pump(1'b0, 0);
    do_pump(1'b0, 0);
    n_vec++; if (bus.row_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got=%b exp=0", bus.row_valid); end
    do_pump(1'b0, 0);
    n_vec++; if (bus.row_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", bus.row_valid); end
    n_vec++; if (bus.row !== 128'h00000044_00000033_00000022_00000011) begin
      n_err++; $display("FAIL single_row got=%h exp=%h", bus.row, 128'h00000044_00000033_00000022_00000011);
    end
    n_vec++; if (fifo_count_o !== CW'(1)) begin n_err++; $display("FAIL single_count got=%0d exp=1", fifo_count_o); end
    bus.row_ready = 1'b1;
    step();
    bus.row_ready = 1'b0;
    n_vec++; if (fifo_count_o !== CW'(0)) begin n_err++; $display("FAIL single_pop_count got=%0d exp=0", fifo_count_o); end
  endtask

  task automatic test_pump_gap();
    clear_sched();
    do_pump(1'b1, 1);
    do_pump(1'b0, 0);
    idle_cycle();
    idle_cycle();
    do_pump(1'b0, 0);
    n_vec++; if (bus.row_valid !== 1'b0) begin n_err++; $display("FAIL gap_early_valid got=%b exp=0", bus.row_valid); end
    do_pump(1'b0, 0);
    n_vec++; if (bus.row_valid !== 1'b1) begin n_err++; $display("FAIL gap_valid got=%b exp=1", bus.row_valid); end
    n_vec++; if (bus.row !== exp_row(1)) begin n_err++; $display("FAIL gap_row got=%h exp=%h", bus.row, exp_row(1)); end
    bus.row_ready = 1'b1;
    step();
    bus.row_ready = 1'b0;
  endtask

  task automatic test_stall_fill();
    int issued = 0;
    bit stall_hist [8];
    clear_sched();
    bus.row_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (!bus.stall && issued < 4) begin
        do_pump(1'b1, issued);
        issued++;
      end else begin
        do_pump(1'b0, 0);
      end
      stall_hist[i] = bus.stall;
    end
    n_vec++; if (stall_hist[2] !== 1'b0) begin n_err++; $display("FAIL fill_stall_p2 got=%b exp=0", stall_hist[2]); end
    n_vec++; if (stall_hist[3] !== 1'b1) begin n_err++; $display("FAIL fill_stall_p3 got=%b exp=1", stall_hist[3]); end
    n_vec++; if (issued != 4) begin n_err++; $display("FAIL fill_issued got=%0d exp=4", issued); end
    n_vec++; if (fifo_count_o !== CW'(4)) begin n_err++; $display("FAIL fill_count got=%0d exp=4", fifo_count_o); end
    n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL fill_overflow got=%b exp=0", overflow_o); end
    n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL fill_stall got=%b exp=1", bus.stall); end
  endtask

  task automatic test_overflow();
    do_pump(1'b1, 4);
    for (int i = 0; i < 3; i++) do_pump(1'b0, 0);
    n_vec++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", overflow_o); end
    n_vec++; if (fifo_count_o !== CW'(4)) begin n_err++; $display("FAIL ovf_count got=%0d exp=4", fifo_count_o); end
    bus.row_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (bus.row !== exp_row(i)) begin n_err++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, bus.row, exp_row(i)); end
      step();
    end
    bus.row_ready = 1'b0;
    n_vec++; if (bus.row_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained got=%b exp=0", bus.row_valid); end
  endtask

  task automatic test_full_push_pop();
    do_flush();
    for (int i = 0; i < 4; i++) do_pump(1'b1, 10 + i);
    for (int i = 0; i < 3; i++) do_pump(1'b0, 0);
    n_vec++; if (fifo_count_o !== CW'(4)) begin n_err++; $display("FAIL pp_full_count got=%0d exp=4", fifo_count_o); end
    do_pump(1'b1, 14);
    do_pump(1'b0, 0);
    do_pump(1'b0, 0);
    bus.row_ready = 1'b1;
    do_pump(1'b0, 0);
    bus.row_ready = 1'b0;
    n_vec++; if (fifo_count_o !== CW'(4)) begin n_err++; $display("FAIL pp_count got=%0d exp=4", fifo_count_o); end
    n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL pp_overflow got=%b exp=0", overflow_o); end
    bus.row_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (bus.row !== exp_row(11 + i)) begin n_err++; $display("FAIL pp_pop%0d got=%h exp=%h", i, bus.row, exp_row(11 + i)); end
`ifdef QUADRILATERO_DESKEW_ROWIDX_EN
      n_vec++; if (32'(bus.row_idx) != (i + 1) % MW) begin n_err++; $display("FAIL pp_idx%0d got=%0d exp=%0d", i, bus.row_idx, (i + 1) % MW); end
`endif
      step();
    end
    bus.row_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_flush();
    do_pump(1'b1, 20);
    do_pump(1'b1, 21);
    do_pump(1'b1, 22);
    do_pump(1'b0, 0);
    do_pump(1'b0, 0);
    n_vec++; if (fifo_count_o !== CW'(2)) begin n_err++; $display("FAIL fl_pre_count got=%0d exp=2", fifo_count_o); end
    do_flush();
    n_vec++; if (bus.row_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid got=%b exp=0", bus.row_valid); end
    n_vec++; if (fifo_count_o !== CW'(0)) begin n_err++; $display("FAIL fl_count got=%0d exp=0", fifo_count_o); end
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL fl_stall got=%b exp=0", bus.stall); end
    do_pump(1'b1, 30);
    for (int i = 0; i < 3; i++) do_pump(1'b0, 0);
    n_vec++; if (fifo_count_o !== CW'(1)) begin n_err++; $display("FAIL fl_post_count got=%0d exp=1", fifo_count_o); end
    n_vec++; if (bus.row !== exp_row(30)) begin n_err++; $display("FAIL fl_post_row got=%h exp=%h", bus.row, exp_row(30)); end
`ifdef QUADRILATERO_DESKEW_ROWIDX_EN
    n_vec++; if (bus.row_idx !== '0) begin n_err++; $display("FAIL fl_idx got=%0d exp=0", bus.row_idx); end
`endif
  endtask

  initial begin
    bus.pump      = 1'b0;
    bus.acc_valid = 1'b0;
    bus.acc       = '0;
    bus.row_ready = 1'b0;
    clear_sched();
    step();
    step();
    test_reset();
    rst_ni = 1'b1;
    step();
    test_single_row();
    test_pump_gap();
    test_stall_fill();
    test_overflow();
    test_full_push_pop();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
